// File: rtl/keyboard_ps2_pkg.sv
// Shared types and frame constants for the PS/2 keyboard receiver.
package keyboard_ps2_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } RxState;

   localparam int   FRAME_BITS = 11;
   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;

endpackage

// File: rtl/keyboard_ps2_fifo.sv
// First-word fall-through scan-code FIFO; a push on a full FIFO is only
// accepted when a pop frees a slot in the same cycle.
module keyboard_ps2_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     iCLOCK,
   input  logic                     iRESET_SYNC,
   input  logic                     iPUSH,
   input  logic                     iPOP,
   input  logic [7:0]               iWR_DATA,
   output logic [7:0]               oRD_DATA,
   output logic                     oFULL,
   output logic                     oEMPTY,
   output logic [$clog2(DEPTH):0]   oCOUNT
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wrPtr;
   logic [AW-1:0] rdPtr;
   logic [AW:0]   count;
   logic          doPush;
   logic          doPop;

   assign oEMPTY   = (count == '0);
   assign oFULL    = (count == FULL_COUNT);
   assign oCOUNT   = count;
   assign doPop    = iPOP && !oEMPTY;
   assign doPush   = iPUSH && (!oFULL || doPop);
   assign oRD_DATA = oEMPTY ? 8'h00 : mem[rdPtr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array is left unreset; empty masks its contents on the read port
   always_ff @(posedge iCLOCK) begin
      if (doPush) mem[wrPtr] <= iWR_DATA;
   end

endmodule

// File: rtl/keyboard_ps2_receiver.sv
// PS/2 keyboard frame receiver: detects falling edges of the PS/2 clock,
// assembles 11-bit frames, checks parity/stop, and queues good scan codes.
module keyboard_ps2_receiver
   import keyboard_ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       iCLOCK,
   input  logic       iRESET_SYNC,
   input  logic       iPS2_CLK,
   input  logic       iPS2_DATA,
   output logic       oRD_VALID,
   output logic [7:0] oRD_DATA,
   input  logic       iRD_ACK,
   output logic       oBUSY,
   output logic       oPARITY_ERR,
   output logic       oFRAME_ERR,
   output logic       oOVERFLOW
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]    LAST_BIT_COUNT = 4'(FRAME_BITS - 1);

   RxState                      state;
   RxState                      stateNext;
   logic                        prevClk;
   logic                        fallEdge;
   logic [3:0]                  bitCount;
   logic [8:0]                  shiftReg;
   logic [TW-1:0]               timeoutCount;
   logic                        frameGood;
   logic                        parityBad;
   logic                        stopBad;
   logic                        timeoutHit;
   logic                        fifoFull;
   logic                        fifoEmpty;
   logic                        fifoPop;
   logic [$clog2(FIFO_DEPTH):0] fifoCount;

   assign fallEdge  = prevClk && !iPS2_CLK;
   assign oBUSY     = (state == RECV);
   assign fifoPop   = iRD_ACK && !fifoEmpty;
   assign oRD_VALID = (fifoCount != '0);

   // State register
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) state <= IDLE;
      else             state <= stateNext;
   end

   // Next state and frame verdict; shiftReg holds {parity, data} when the stop bit arrives
   always_comb begin
      stateNext  = state;
      frameGood  = 1'b0;
      parityBad  = 1'b0;
      stopBad    = 1'b0;
      timeoutHit = 1'b0;
      unique case (state)
         IDLE: begin
            if (fallEdge && (iPS2_DATA == START_BIT)) stateNext = RECV;
         end
         RECV: begin
            if (fallEdge) begin
               if (bitCount == LAST_BIT_COUNT) begin
                  stateNext = IDLE;
                  if (iPS2_DATA != STOP_BIT)  stopBad   = 1'b1;
                  else if (!(^shiftReg))      parityBad = 1'b1;
                  else                        frameGood = 1'b1;
               end
            end else if (timeoutCount == TIMEOUT_LAST) begin
               stateNext  = IDLE;
               timeoutHit = 1'b1;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // Edge history, bit shifting, bit counting and the no-edge watchdog
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         prevClk      <= 1'b1;
         bitCount     <= '0;
         shiftReg     <= '0;
         timeoutCount <= '0;
      end else begin
         prevClk <= iPS2_CLK;
         if (state == IDLE) begin
            timeoutCount <= '0;
            if (fallEdge && (iPS2_DATA == START_BIT)) begin
               bitCount <= 4'd1;
               shiftReg <= '0;
            end
         end else if (fallEdge) begin
            timeoutCount <= '0;
            shiftReg     <= {iPS2_DATA, shiftReg[8:1]};
            if (bitCount == LAST_BIT_COUNT) bitCount <= '0;
            else                            bitCount <= bitCount + 1'b1;
         end else if (timeoutHit) begin
            timeoutCount <= '0;
            bitCount     <= '0;
            shiftReg     <= '0;
         end else begin
            timeoutCount <= timeoutCount + 1'b1;
         end
      end
   end

   // Registered one-cycle status pulses
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         oPARITY_ERR <= 1'b0;
         oFRAME_ERR  <= 1'b0;
         oOVERFLOW   <= 1'b0;
      end else begin
         oPARITY_ERR <= parityBad;
         oFRAME_ERR  <= stopBad || timeoutHit;
         oOVERFLOW   <= frameGood && fifoFull && !iRD_ACK;
      end
   end

   keyboard_ps2_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) scanFifo (
      .iCLOCK      (iCLOCK),
      .iRESET_SYNC (iRESET_SYNC),
      .iPUSH       (frameGood),
      .iPOP        (fifoPop),
      .iWR_DATA    (shiftReg[7:0]),
      .oRD_DATA    (oRD_DATA),
      .oFULL       (fifoFull),
      .oEMPTY      (fifoEmpty),
      .oCOUNT      (fifoCount)
   );

endmodule

// File: tb/tb_keyboard_ps2_receiver.sv
// Directed self-checking bench for the PS/2 keyboard receiver.
module tb_keyboard_ps2_receiver;

   localparam int DEPTH = 8;
   localparam int TMO   = 200;
   localparam int HALF  = 10;

   logic       iCLOCK = 1'b0;
   logic       iRESET_SYNC = 1'b1;
   logic       ps2Clk = 1'b1;
   logic       ps2Data = 1'b1;
   logic       rdAck = 1'b0;
   logic       rdValid;
   logic [7:0] rdData;
   logic       busy;
   logic       parityErr;
   logic       frameErr;
   logic       overflow;

   int checks = 0;
   int failures = 0;
   int parCnt = 0;
   int frmCnt = 0;
   int ovfCnt = 0;

   keyboard_ps2_receiver #(
      .FIFO_DEPTH(DEPTH),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .iCLOCK      (iCLOCK),
      .iRESET_SYNC (iRESET_SYNC),
      .iPS2_CLK    (ps2Clk),
      .iPS2_DATA   (ps2Data),
      .oRD_VALID   (rdValid),
      .oRD_DATA    (rdData),
      .iRD_ACK     (rdAck),
      .oBUSY       (busy),
      .oPARITY_ERR (parityErr),
      .oFRAME_ERR  (frameErr),
      .oOVERFLOW   (overflow)
   );

   // 100 MHz-style bench clock; absolute rate is irrelevant to the DUT
   always #5 iCLOCK = ~iCLOCK;

   // Count high cycles of each status pulse so tests can check exact pulse counts
   always @(negedge iCLOCK) begin
      if (parityErr) parCnt <= parCnt + 1;
      if (frameErr)  frmCnt <= frmCnt + 1;
      if (overflow)  ovfCnt <= ovfCnt + 1;
   end

   task automatic sendBit(input logic b);
      @(negedge iCLOCK);
      ps2Data = b;
      repeat (HALF) @(negedge iCLOCK);
      ps2Clk = 1'b0;
      repeat (HALF) @(negedge iCLOCK);
      ps2Clk = 1'b1;
   endtask

   // Start bit, eight data bits LSB first and parity; the stop bit is left to the caller
   task automatic sendHead(input logic [7:0] d, input logic par);
      sendBit(1'b0);
      for (int i = 0; i < 8; i++) sendBit(d[i]);
      sendBit(par);
   endtask

   task automatic sendFrame(input logic [7:0] d, input logic par, input logic stop);
      sendHead(d, par);
      sendBit(stop);
      ps2Data = 1'b1;
   endtask

   task automatic popOne();
      @(negedge iCLOCK);
      rdAck = 1'b1;
      @(negedge iCLOCK);
      rdAck = 1'b0;
   endtask

   task automatic test_reset();
      iRESET_SYNC = 1'b1;
      repeat (3) @(negedge iCLOCK);
      checks++;
      if (rdValid !== 1'b0 || rdData !== 8'h00 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_outputs: valid=%b data=%h busy=%b required 0 00 0", rdValid, rdData, busy);
      end
      checks++;
      if (parityErr !== 1'b0 || frameErr !== 1'b0 || overflow !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_pulses: par=%b frm=%b ovf=%b required 000", parityErr, frameErr, overflow);
      end
      iRESET_SYNC = 1'b0;
      repeat (2) @(negedge iCLOCK);
   endtask

   task automatic test_good_frame();
      int p0, f0;
      p0 = parCnt;
      f0 = frmCnt;
      sendHead(8'h1C, 1'b0);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL busy_mid_frame: got %b required 1", busy);
      end
      @(negedge iCLOCK);
      ps2Data = 1'b1;
      repeat (HALF) @(negedge iCLOCK);
      ps2Clk = 1'b0;
      checks++;
      if (rdValid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL valid_before_edge: got %b required 0", rdValid);
      end
      @(negedge iCLOCK);
      checks++;
      if (rdValid !== 1'b1 || rdData !== 8'h1C) begin
         failures++;
         $display("[TB] FAIL good_frame_latency: valid=%b data=%h required 1 1c", rdValid, rdData);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL busy_after_frame: got %b required 0", busy);
      end
      repeat (HALF - 1) @(negedge iCLOCK);
      ps2Clk = 1'b1;
      checks++;
      if (parCnt - p0 !== 0 || frmCnt - f0 !== 0) begin
         failures++;
         $display("[TB] FAIL good_frame_errors: par=%0d frm=%0d required 0 0", parCnt - p0, frmCnt - f0);
      end
      popOne();
      checks++;
      if (rdValid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL pop_to_empty: valid=%b required 0", rdValid);
      end
   endtask

   task automatic test_parity_error();
      int p0, f0;
      p0 = parCnt;
      f0 = frmCnt;
      sendFrame(8'hF0, 1'b0, 1'b1);
      repeat (3) @(negedge iCLOCK);
      checks++;
      if (parCnt - p0 !== 1 || frmCnt - f0 !== 0) begin
         failures++;
         $display("[TB] FAIL parity_error_pulse: par=%0d frm=%0d required 1 0", parCnt - p0, frmCnt - f0);
      end
      checks++;
      if (rdValid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL parity_error_nopush: valid=%b required 0", rdValid);
      end
   endtask

   task automatic test_stop_error();
      int p0, f0;
      p0 = parCnt;
      f0 = frmCnt;
      sendFrame(8'h1C, 1'b0, 1'b0);
      repeat (3) @(negedge iCLOCK);
      checks++;
      if (frmCnt - f0 !== 1 || parCnt - p0 !== 0) begin
         failures++;
         $display("[TB] FAIL stop_error_pulse: frm=%0d par=%0d required 1 0", frmCnt - f0, parCnt - p0);
      end
      checks++;
      if (rdValid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL stop_error_nopush: valid=%b required 0", rdValid);
      end
   endtask

   task automatic test_timeout();
      int f0;
      f0 = frmCnt;
      sendBit(1'b0);
      sendBit(1'b1);
      sendBit(1'b0);
      sendBit(1'b1);
      ps2Data = 1'b1;
      repeat (TMO / 2) @(negedge iCLOCK);
      checks++;
      if (busy !== 1'b1 || frmCnt - f0 !== 0) begin
         failures++;
         $display("[TB] FAIL timeout_early: busy=%b frm=%0d required 1 0", busy, frmCnt - f0);
      end
      repeat (TMO) @(negedge iCLOCK);
      checks++;
      if (busy !== 1'b0 || frmCnt - f0 !== 1) begin
         failures++;
         $display("[TB] FAIL timeout_abort: busy=%b frm=%0d required 0 1", busy, frmCnt - f0);
      end
      sendFrame(8'h1C, 1'b0, 1'b1);
      repeat (2) @(negedge iCLOCK);
      checks++;
      if (rdValid !== 1'b1 || rdData !== 8'h1C) begin
         failures++;
         $display("[TB] FAIL after_timeout_frame: valid=%b data=%h required 1 1c", rdValid, rdData);
      end
      popOne();
   endtask

   task automatic test_overflow();
      int o0;
      logic [7:0] d;
      o0 = ovfCnt;
      for (int i = 0; i < 9; i++) begin
         d = 8'h10 + 8'(i);
         sendFrame(d, ~^d, 1'b1);
      end
      repeat (3) @(negedge iCLOCK);
      checks++;
      if (ovfCnt - o0 !== 1) begin
         failures++;
         $display("[TB] FAIL overflow_pulse: got %0d required 1", ovfCnt - o0);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (rdValid !== 1'b1 || rdData !== 8'h10 + 8'(i)) begin
            failures++;
            $display("[TB] FAIL overflow_drain[%0d]: valid=%b data=%h required 1 %h", i, rdValid, rdData, 8'h10 + 8'(i));
         end
         popOne();
      end
      checks++;
      if (rdValid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL overflow_empty: valid=%b required 0", rdValid);
      end
   endtask

   task automatic test_full_push_pop();
      int o0;
      logic [7:0] d;
      o0 = ovfCnt;
      for (int i = 0; i < 8; i++) begin
         d = 8'h20 + 8'(i);
         sendFrame(d, ~^d, 1'b1);
      end
      d = 8'h28;
      sendHead(d, ~^d);
      @(negedge iCLOCK);
      ps2Data = 1'b1;
      repeat (HALF) @(negedge iCLOCK);
      ps2Clk = 1'b0;
      rdAck = 1'b1;
      @(negedge iCLOCK);
      rdAck = 1'b0;
      repeat (HALF - 1) @(negedge iCLOCK);
      ps2Clk = 1'b1;
      repeat (2) @(negedge iCLOCK);
      checks++;
      if (ovfCnt - o0 !== 0) begin
         failures++;
         $display("[TB] FAIL full_push_pop_overflow: got %0d required 0", ovfCnt - o0);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (rdValid !== 1'b1 || rdData !== 8'h21 + 8'(i)) begin
            failures++;
            $display("[TB] FAIL full_push_pop_drain[%0d]: valid=%b data=%h required 1 %h", i, rdValid, rdData, 8'h21 + 8'(i));
         end
         popOne();
      end
      checks++;
      if (rdValid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL full_push_pop_empty: valid=%b required 0", rdValid);
      end
   endtask

   task automatic test_ack_empty();
      popOne();
      popOne();
      sendFrame(8'hA5, 1'b1, 1'b1);
      repeat (2) @(negedge iCLOCK);
      checks++;
      if (rdValid !== 1'b1 || rdData !== 8'hA5) begin
         failures++;
         $display("[TB] FAIL ack_empty_then_push: valid=%b data=%h required 1 a5", rdValid, rdData);
      end
      popOne();
      checks++;
      if (rdValid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL ack_empty_single_pop: valid=%b required 0", rdValid);
      end
   endtask

   task automatic test_reset_mid_frame();
      int p0, f0, o0;
      sendFrame(8'h55, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) sendBit(i[0]);
      p0 = parCnt;
      f0 = frmCnt;
      o0 = ovfCnt;
      checks++;
      if (busy !== 1'b1 || rdValid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL pre_reset_state: busy=%b valid=%b required 1 1", busy, rdValid);
      end
      @(negedge iCLOCK);
      iRESET_SYNC = 1'b1;
      @(negedge iCLOCK);
      checks++;
      if (busy !== 1'b0 || rdValid !== 1'b0 || rdData !== 8'h00) begin
         failures++;
         $display("[TB] FAIL mid_frame_reset: busy=%b valid=%b data=%h required 0 0 00", busy, rdValid, rdData);
      end
      iRESET_SYNC = 1'b0;
      ps2Data = 1'b1;
      repeat (4) @(negedge iCLOCK);
      checks++;
      if (parCnt - p0 !== 0 || frmCnt - f0 !== 0 || ovfCnt - o0 !== 0) begin
         failures++;
         $display("[TB] FAIL mid_frame_reset_pulses: par=%0d frm=%0d ovf=%0d required 0 0 0", parCnt - p0, frmCnt - f0, ovfCnt - o0);
      end
      sendFrame(8'h1C, 1'b0, 1'b1);
      repeat (2) @(negedge iCLOCK);
      checks++;
      if (rdValid !== 1'b1 || rdData !== 8'h1C) begin
         failures++;
         $display("[TB] FAIL after_reset_frame: valid=%b data=%h required 1 1c", rdValid, rdData);
      end
      popOne();
   endtask

   // Run every scenario in order, then report
   initial begin
      test_reset();
      test_good_frame();
      test_parity_error();
      test_stop_error();
      test_timeout();
      test_overflow();
      test_full_push_pop();
      test_ack_empty();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/keyboard_ps2_receiver.md
KEYBOARD_PS2_RECEIVER -- requirements
Module: keyboard_ps2_receiver

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, number of received scan-code entries buffered; power of two, minimum 2.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000, iCLOCK cycles without a PS/2 clock falling edge before a partial frame is aborted (2 ms at 50 MHz).
REQ-003 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-004 iCLOCK  input  1  system clock, 50 MHz.
REQ-005 iRESET_SYNC  input  1  synchronous active-high reset.
REQ-006 iPS2_CLK  input  1  PS/2 clock line, already debounced and synchronous to iCLOCK.
REQ-007 iPS2_DATA  input  1  PS/2 data line, already debounced and synchronous to iCLOCK.
REQ-008 oRD_VALID  output  1  FIFO non-empty; oRD_DATA holds the oldest entry.
REQ-009 oRD_DATA  output  8  oldest received scan code, first-word fall-through.
REQ-010 iRD_ACK  input  1  pop the oldest entry this cycle.
REQ-011 oBUSY  output  1  high while a frame is in progress.
REQ-012 oPARITY_ERR  output  1  one-cycle pulse when a frame has bad parity.
REQ-013 oFRAME_ERR  output  1  one-cycle pulse on a bad stop bit or a timeout.
REQ-014 oOVERFLOW  output  1  one-cycle pulse when a good frame is dropped because the FIFO is full.

Function
REQ-015 Falling edge SHALL be detected as previous-sample 1 and current iPS2_CLK 0; the previous-sample register resets to 1.
REQ-016 iPS2_DATA SHALL be sampled in the same cycle the falling edge is detected.
REQ-017 Frame format SHALL be 11 bits: start bit (0), 8 data bits LSB first, odd parity, stop bit (1).
REQ-018 State machine SHALL have two states, IDLE and RECV; oBUSY = (state == RECV).
REQ-019 In IDLE, an edge with data 0 SHALL enter RECV with bit count 1; an edge with data 1 SHALL be ignored and the state stays IDLE.
REQ-020 In RECV, each edge SHALL shift in one bit and increment a 4-bit bit count.
REQ-021 On the edge that brings the bit count to 11, the frame SHALL be evaluated in that cycle and the state returns to IDLE.
REQ-022 Frame is good iff XOR of the 8 data bits and the parity bit = 1 and the stop bit = 1.
REQ-023 A good frame SHALL be pushed at that clock edge; oRD_VALID/oRD_DATA reflect it the following cycle.
REQ-024 Bad parity with stop bit = 1: pulse oPARITY_ERR, no push.
REQ-025 Stop bit = 0: pulse oFRAME_ERR only, no push, regardless of parity.
REQ-026 Timeout counter SHALL clear on every edge and on entry to RECV, and increment each RECV cycle.
REQ-027 On reaching TIMEOUT_CYCLES-1 without an edge: return to IDLE, discard the partial frame, pulse oFRAME_ERR.
REQ-028 Timeout SHALL NOT run in IDLE.
REQ-029 Push while full: drop the frame and pulse oOVERFLOW, unless iRD_ACK is high in the same cycle, in which case push and pop both occur and the count is unchanged.
REQ-030 iRD_ACK while empty SHALL be ignored.
REQ-031 Simultaneous push and pop when not full SHALL leave the count unchanged.
REQ-032 Pointers SHALL wrap modulo FIFO_DEPTH; the count width is log2(FIFO_DEPTH)+1.

Reset
REQ-033 On iRESET_SYNC: state IDLE, bit count 0, shift register 0, timeout counter 0, previous clock sample 1, FIFO empty.
REQ-034 Output values during and after reset: oRD_VALID=0, oRD_DATA=0, oBUSY=0, all error pulses 0.
REQ-035 Reset mid-frame SHALL discard the partial frame with no error pulse; the FIFO contents are lost.

Structure
REQ-036 Package keyboard_ps2_pkg SHALL hold the state enum, FRAME_BITS=11, and the start/stop bit constants.
REQ-037 The FIFO SHALL be the sub-module keyboard_ps2_fifo (parameter DEPTH, 8-bit width, FWFT, push/pop/full/empty/count).

Verification
REQ-038 Frame 0x1C (parity 0, stop 1) -> one cycle after the 11th edge, oRD_VALID=1 and oRD_DATA=0x1C; no error pulses.
REQ-039 Frame 0xF0 with parity 0 (wrong) -> oPARITY_ERR pulses once, oRD_VALID stays 0.
REQ-040 Frame 0x1C with stop 0 -> oFRAME_ERR pulses once, no push.
REQ-041 Four bits, then idle for TIMEOUT_CYCLES -> oFRAME_ERR pulses, oBUSY falls; a following 0x1C frame is received correctly.
REQ-042 Nine good frames with no iRD_ACK -> 8 stored, oOVERFLOW pulses on the 9th; the same case with iRD_ACK on the 9th push cycle stores it with no oOVERFLOW.
REQ-043 Assert iRESET_SYNC after the 6th edge -> oBUSY=0 next cycle, no error pulse; the next full frame is received correctly.
